// File: rtl/enigma_pkg.sv
// enigma_pkg: types and constants shared by the enigma drain top and its
// completion FIFO.
//   ENIGMA_PAYLOAD_W / ENIGMA_ID_W / ENIGMA_QOS_W : C-port field widths
//   enigma_beat_t        : one stored beat {payload, id, qos}
//   enigma_drain_state_e : service FSM states
//   svc_load()           : service timer load value for a given qos
package enigma_pkg;

   localparam int ENIGMA_PAYLOAD_W = 128;
   localparam int ENIGMA_ID_W      = 6;
   localparam int ENIGMA_QOS_W     = 2;

   typedef struct packed {
      logic [ENIGMA_PAYLOAD_W-1:0] payload;
      logic [ENIGMA_ID_W-1:0]      id;
      logic [ENIGMA_QOS_W-1:0]     qos;
   } enigma_beat_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVICE = 2'd1,
      RETIRE  = 2'd2
   } enigma_drain_state_e;

   // Higher qos shortens service: timer starts at SVC_LAT - qos.
   function automatic logic [7:0] svc_load(input logic [7:0]              svc_lat,
                                           input logic [ENIGMA_QOS_W-1:0] qos);
      return svc_lat - {6'd0, qos};
   endfunction

endpackage

// File: rtl/enigma_drain_fifo.sv
// enigma_drain_fifo: synchronous completion FIFO of enigma_beat_t.
// Supports push and pop on the same edge (count unchanged). A push into a
// full FIFO is dropped unless a pop happens on the same edge; a pop on an
// empty FIFO is ignored. Storage is not reset; only pointers/count are.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   push, push_data   : write request and beat
//   pop               : remove head
//   head, head_next   : current head and the entry behind it
//   count, count_next : occupancy now and after this edge
//   full, empty       : occupancy flags
module enigma_drain_fifo
   import enigma_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  enigma_beat_t           push_data,
   output enigma_beat_t           head,
   output enigma_beat_t           head_next,
   output logic [$clog2(DEPTH):0] count,
   output logic [$clog2(DEPTH):0] count_next,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   enigma_beat_t  mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          do_push_s;
   logic          do_pop_s;

   // Qualify requests against occupancy and derive the next count.
   always_comb begin
      do_pop_s  = pop && (count_r != CW'(0));
      do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
      case ({do_push_s, do_pop_s})
         2'b10:   count_next = count_r + CW'(1);
         2'b01:   count_next = count_r - CW'(1);
         default: count_next = count_r;
      endcase
   end

   // Pointer and count registers; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= AW'(0);
         rd_ptr_r <= AW'(0);
         count_r  <= CW'(0);
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         count_r <= count_next;
      end
   end

   // Beat storage write port.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   assign head      = mem_r[rd_ptr_r];
   assign head_next = mem_r[rd_ptr_r + AW'(1)];
   assign count     = count_r;
   assign full      = (count_r == CW'(DEPTH));
   assign empty     = (count_r == CW'(0));

endmodule

// File: rtl/enigma_drain.sv
// enigma_drain: consumer of the enigma buffer's C port.
// Accepts beats on a valid/ready handshake, tracks outstanding ids in a
// busy scoreboard, drops (and flags on conflict_c) beats whose id is still
// busy, and retires stored beats in order after SVC_LAT - qos service
// cycles, announcing each on release_c/releaseid_c and the mon_* port.
// Optional build macro ENIGMA_DRAIN_THROTTLE_EN adds LFSR-driven random
// backpressure on ready_c.
// Ports:
//   clk, rst                        : clock, synchronous active-high reset
//   valid_c/ready_c                 : C-port handshake (ready_c registered)
//   payload_c, id_c, qos_c          : C-port beat fields
//   conflict_c                      : pulse, last accepted beat hit a busy id
//   release_c, releaseid_c          : pulse and id of a retirement
//   mon_valid, mon_payload/id/qos   : retired beat, same cycle as release_c
//   outstanding                     : live FIFO occupancy
module enigma_drain
   import enigma_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int SVC_LAT = 6,
   parameter int ID_W    = ENIGMA_ID_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        valid_c,
   output logic                        ready_c,
   input  logic [ENIGMA_PAYLOAD_W-1:0] payload_c,
   input  logic [ENIGMA_ID_W-1:0]      id_c,
   input  logic [ENIGMA_QOS_W-1:0]     qos_c,
   output logic                        conflict_c,
   output logic                        release_c,
   output logic [ENIGMA_ID_W-1:0]      releaseid_c,
   output logic                        mon_valid,
   output logic [ENIGMA_PAYLOAD_W-1:0] mon_payload,
   output logic [ENIGMA_ID_W-1:0]      mon_id,
   output logic [ENIGMA_QOS_W-1:0]     mon_qos,
   output logic [$clog2(DEPTH):0]      outstanding
);

   localparam int         CW        = $clog2(DEPTH) + 1;
   localparam int         NID       = 2 ** ID_W;
   localparam logic [7:0] SVC_LAT_V = 8'(SVC_LAT);

   enigma_drain_state_e state_r;
   logic [7:0]          timer_r;
   logic [NID-1:0]      busy_r;
   logic [NID-1:0]      busy_next_s;

   enigma_beat_t        push_beat_s;
   enigma_beat_t        head_s;
   enigma_beat_t        head_next_s;
   enigma_beat_t        reload_beat_s;
   logic [CW-1:0]       count_s;
   logic [CW-1:0]       count_next_s;
   logic                full_s;
   logic                empty_s;

   logic                accept_s;
   logic                hit_s;
   logic                push_s;
   logic                pop_s;
   logic                throttle_s;

   assign push_beat_s = '{payload: payload_c, id: id_c, qos: qos_c};

   // Accept decode against the scoreboard as it looks after this edge's
   // release, so a beat reusing the id being retired is stored, not flagged.
   // Also picks the beat the service timer reloads from after a pop: the
   // entry behind the head, or the beat pushed this edge if it becomes head.
   always_comb begin
      accept_s    = valid_c && ready_c;
      pop_s       = (state_r == RETIRE);
      busy_next_s = busy_r;
      if (pop_s) begin
         busy_next_s[head_s.id] = 1'b0;
      end else begin
         busy_next_s[head_s.id] = busy_r[head_s.id];
      end
      hit_s = busy_next_s[id_c];
      if (accept_s && !hit_s && (!full_s || pop_s)) begin
         push_s             = 1'b1;
         busy_next_s[id_c]  = 1'b1;
      end else begin
         push_s = 1'b0;
      end
      if (count_s > CW'(1)) begin
         reload_beat_s = head_next_s;
      end else begin
         reload_beat_s = push_beat_s;
      end
   end

`ifdef ENIGMA_DRAIN_THROTTLE_EN
   logic [15:0] lfsr_r;
   logic [15:0] lfsr_next_s;

   // Fibonacci LFSR step, taps 16,14,13,11.
   always_comb begin
      lfsr_next_s = {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
   end

   // LFSR state, free-running every cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_r <= 16'hACE1;
      end else begin
         lfsr_r <= lfsr_next_s;
      end
   end

   // ready_c is registered, so gate on the LFSR value it will be seen with.
   assign throttle_s = (lfsr_next_s[1:0] == 2'b00);
`else
   assign throttle_s = 1'b0;
`endif

   enigma_drain_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push_s),
      .pop        (pop_s),
      .push_data  (push_beat_s),
      .head       (head_s),
      .head_next  (head_next_s),
      .count      (count_s),
      .count_next (count_next_s),
      .full       (full_s),
      .empty      (empty_s)
   );

   // Service FSM, scoreboard and all registered C-port/monitor outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         timer_r     <= 8'd0;
         busy_r      <= {NID{1'b0}};
         ready_c     <= 1'b0;
         conflict_c  <= 1'b0;
         release_c   <= 1'b0;
         releaseid_c <= {ENIGMA_ID_W{1'b0}};
         mon_valid   <= 1'b0;
         mon_payload <= {ENIGMA_PAYLOAD_W{1'b0}};
         mon_id      <= {ENIGMA_ID_W{1'b0}};
         mon_qos     <= {ENIGMA_QOS_W{1'b0}};
      end else begin
         busy_r     <= busy_next_s;
         ready_c    <= (count_next_s < CW'(DEPTH)) && !throttle_s;
         conflict_c <= accept_s && hit_s;
         release_c  <= 1'b0;
         mon_valid  <= 1'b0;
         case (state_r)
            IDLE: begin
               if (!empty_s) begin
                  timer_r <= svc_load(SVC_LAT_V, head_s.qos);
                  state_r <= SERVICE;
               end else begin
                  state_r <= IDLE;
               end
            end
            SERVICE: begin
               if (timer_r == 8'd1) begin
                  state_r <= RETIRE;
               end else begin
                  timer_r <= timer_r - 8'd1;
               end
            end
            RETIRE: begin
               release_c   <= 1'b1;
               releaseid_c <= head_s.id;
               mon_valid   <= 1'b1;
               mon_payload <= head_s.payload;
               mon_id      <= head_s.id;
               mon_qos     <= head_s.qos;
               // Skip IDLE when work remains so retires stay back-to-back.
               if (count_next_s != CW'(0)) begin
                  timer_r <= svc_load(SVC_LAT_V, reload_beat_s.qos);
                  state_r <= SERVICE;
               end else begin
                  state_r <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign outstanding = count_s;

endmodule

// File: tb/tb_enigma_drain.sv
// tb_enigma_drain: self-checking bench for enigma_drain (default build).
// Reference model: an in-order queue of beats, each stamped with the clock
// edge at which it must retire, plus a per-id busy table.
module tb_enigma_drain;
   import enigma_pkg::*;

   localparam int DEPTH   = 8;
   localparam int SVC_LAT = 6;

   logic         clk = 1'b0;
   logic         rst;
   logic         valid_c;
   logic         ready_c;
   logic [127:0] payload_c;
   logic [5:0]   id_c;
   logic [1:0]   qos_c;
   logic         conflict_c;
   logic         release_c;
   logic [5:0]   releaseid_c;
   logic         mon_valid;
   logic [127:0] mon_payload;
   logic [5:0]   mon_id;
   logic [1:0]   mon_qos;
   logic [3:0]   outstanding;

   enigma_drain #(.DEPTH(DEPTH), .SVC_LAT(SVC_LAT), .ID_W(6)) dut (
      .clk(clk), .rst(rst), .valid_c(valid_c), .ready_c(ready_c),
      .payload_c(payload_c), .id_c(id_c), .qos_c(qos_c),
      .conflict_c(conflict_c), .release_c(release_c), .releaseid_c(releaseid_c),
      .mon_valid(mon_valid), .mon_payload(mon_payload), .mon_id(mon_id),
      .mon_qos(mon_qos), .outstanding(outstanding)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] payload;
      logic [5:0]   id;
      logic [1:0]   qos;
      int           ret;
   } ent_t;

   ent_t         q[$];
   bit           busy_m[64];
   int           edge_n = 0;
   int           n_vec  = 0;
   int           n_miss = 0;
   bit           exp_ready, exp_conflict, exp_release;
   logic [5:0]   exp_rid;
   logic [127:0] exp_pay;
   logic [1:0]   exp_qos;
   int           n_rel = 0;
   int           rel9 = 0;
   int           last_rel_edge = -1;
   int           a_edge;
   int           r0;

   task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Model of one clock edge: retire first, then accept.
   task automatic model_edge(bit r, bit v, logic [5:0] id, logic [1:0] qs, logic [127:0] p);
      ent_t e;
      bit   popped;
      edge_n++;
      exp_conflict = 1'b0;
      exp_release  = 1'b0;
      if (r) begin
         q.delete();
         foreach (busy_m[i]) busy_m[i] = 1'b0;
         exp_ready = 1'b0;
         return;
      end
      popped = 1'b0;
      if (q.size() > 0 && q[0].ret == edge_n) begin
         e = q.pop_front();
         popped = 1'b1;
         exp_release = 1'b1;
         exp_rid = e.id; exp_pay = e.payload; exp_qos = e.qos;
         busy_m[e.id] = 1'b0;
         if (q.size() > 0) q[0].ret = edge_n + (SVC_LAT - int'(q[0].qos)) + 1;
      end
      if (v && exp_ready) begin
         if (busy_m[id]) begin
            exp_conflict = 1'b1;
         end else begin
            e.payload = p; e.id = id; e.qos = qs;
            if (q.size() == 0) e.ret = edge_n + (SVC_LAT - int'(qs)) + (popped ? 1 : 2);
            else e.ret = 0;
            q.push_back(e);
            busy_m[id] = 1'b1;
         end
      end
      exp_ready = (q.size() < DEPTH);
   endtask

   task automatic compare_all();
      check("ready_c", ready_c, exp_ready);
      check("conflict_c", conflict_c, exp_conflict);
      check("release_c", release_c, exp_release);
      check("mon_valid", mon_valid, exp_release);
      check("outstanding", outstanding, q.size());
      if (exp_release) begin
         check("releaseid_c", releaseid_c, exp_rid);
         check("mon_id", mon_id, exp_rid);
         check("mon_payload", mon_payload, exp_pay);
         check("mon_qos", mon_qos, exp_qos);
      end
      if (release_c === 1'b1) begin
         n_rel++;
         last_rel_edge = edge_n;
         if (releaseid_c == 6'd9) rel9++;
      end
   endtask

   task automatic step(bit r, bit v, logic [5:0] id, logic [1:0] qs);
      logic [127:0] p;
      p = {$urandom, $urandom, $urandom, $urandom};
      rst = r; valid_c = v; id_c = id; qos_c = qs; payload_c = p;
      @(posedge clk);
      model_edge(r, v, id, qs, p);
      #1;
      compare_all();
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 6'd0, 2'd0);
   endtask

   task automatic check_all_zero(string tag);
      check({tag, "_ready"}, ready_c, 1'b0);
      check({tag, "_conflict"}, conflict_c, 1'b0);
      check({tag, "_release"}, release_c, 1'b0);
      check({tag, "_releaseid"}, releaseid_c, 6'd0);
      check({tag, "_mon_valid"}, mon_valid, 1'b0);
      check({tag, "_mon_payload"}, mon_payload, 128'd0);
      check({tag, "_mon_id"}, mon_id, 6'd0);
      check({tag, "_mon_qos"}, mon_qos, 2'd0);
      check({tag, "_outstanding"}, outstanding, 4'd0);
   endtask

   initial begin
      rst = 1'b1; valid_c = 1'b0; id_c = 6'd0; qos_c = 2'd0; payload_c = 128'd0;

      // Reset state
      step(1'b1, 1'b0, 6'd0, 2'd0);
      step(1'b1, 1'b0, 6'd0, 2'd0);
      check_all_zero("reset");
      idle();
      check("ready_after_reset", ready_c, 1'b1);

      // Single beat, qos 0: release 8 edges after accept
      step(1'b0, 1'b1, 6'd5, 2'd0);
      a_edge = edge_n; r0 = n_rel; last_rel_edge = -1;
      for (int k = 0; k < 40 && n_rel == r0; k++) idle();
      check("lat_qos0", last_rel_edge - a_edge, 8);
      check("single_relid", releaseid_c, 6'd5);
      idle();
      check("single_empty", outstanding, 4'd0);

      // Conflict: id 9 twice, two cycles apart
      rel9 = 0;
      step(1'b0, 1'b1, 6'd9, 2'd1);
      idle();
      step(1'b0, 1'b1, 6'd9, 2'd1);
      check("conflict_pulse", conflict_c, 1'b1);
      check("conflict_outst", outstanding, 4'd1);
      idle();
      check("conflict_one_cycle", conflict_c, 1'b0);

      // Overlap: re-present id 9 on the edge it retires
      for (int k = 0; k < 30 && q.size() > 0 && q[0].ret != edge_n + 1; k++) idle();
      step(1'b0, 1'b1, 6'd9, 2'd2);
      check("overlap_release", release_c, 1'b1);
      check("overlap_no_conflict", conflict_c, 1'b0);
      check("overlap_outst", outstanding, 4'd1);
      for (int k = 0; k < 40 && q.size() > 0; k++) idle();
      idle();
      check("id9_releases", rel9, 2);

      // Full: 8 distinct ids back to back
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 6'(10 + i), 2'd0);
      check("full_ready_low", ready_c, 1'b0);
      check("full_outst", outstanding, 4'd8);
      r0 = n_rel;
      for (int k = 0; k < 40 && n_rel == r0; k++) idle();
      check("full_first_relid", releaseid_c, 6'd10);
      check("full_ready_back", ready_c, 1'b1);
      for (int k = 0; k < 200 && q.size() > 0; k++) idle();
      idle();

      // QoS 3: release 5 edges after accept
      step(1'b0, 1'b1, 6'd20, 2'd3);
      a_edge = edge_n; r0 = n_rel; last_rel_edge = -1;
      for (int k = 0; k < 40 && n_rel == r0; k++) idle();
      check("lat_qos3", last_rel_edge - a_edge, 5);
      idle();

      // Reset mid-operation with three entries pending
      step(1'b0, 1'b1, 6'd30, 2'd0);
      step(1'b0, 1'b1, 6'd31, 2'd1);
      step(1'b0, 1'b1, 6'd32, 2'd2);
      check("pre_reset_outst", outstanding, 4'd3);
      step(1'b1, 1'b0, 6'd0, 2'd0);
      check_all_zero("midreset");
      r0 = n_rel;
      for (int k = 0; k < 20; k++) idle();
      check("no_release_after_reset", n_rel - r0, 0);
      check("ready_after_midreset", ready_c, 1'b1);
      step(1'b0, 1'b1, 6'd30, 2'd0);
      check("reaccept30", conflict_c, 1'b0);
      step(1'b0, 1'b1, 6'd31, 2'd0);
      step(1'b0, 1'b1, 6'd32, 2'd0);
      check("reaccept_outst", outstanding, 4'd3);

      // Randomized traffic on a small id range to provoke conflicts
      for (int k = 0; k < 500; k++) begin
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 60),
              6'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      end
      for (int k = 0; k < 120; k++) idle();
      check("final_drained", outstanding, 4'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
